// File: rtl/axis_packet_accumulator.sv
// Purpose : sums the byte-masked words of each tlast-delimited AXI-Stream packet into one wide result beat.
// Latency : result beat is valid the cycle after the terminating input beat.
// Backpr. : input tready drops while a result is held; the result holds stable until m03_axis_tready.
//
// Ports:
//   s03_axis_aclk / s03_axis_aresetn : clock (rising edge), asynchronous active-low reset
//   s03_axis_t*                      : input word stream (tdata/tstrb/tvalid/tlast, tready out)
//   m03_axis_t*                      : one-beat result stream (sum, all-ones strobe, tlast == tvalid)
//   beat_count                       : beats in the reported packet
//   pkt_err                          : reported packet was cut at MAX_BEATS without tlast
//
// Build option: define ACC_SATURATE_EN to clamp the sum at all-ones instead of wrapping.
module axis_packet_accumulator #(
    parameter int DATA_WIDTH = 32,
    parameter int ACC_WIDTH  = 40,
    parameter int MAX_BEATS  = 256,
    parameter int CNT_WIDTH  = 9
) (
    input  logic                    s03_axis_aclk,
    input  logic                    s03_axis_aresetn,
    input  logic [DATA_WIDTH-1:0]   s03_axis_tdata,
    input  logic [DATA_WIDTH/8-1:0] s03_axis_tstrb,
    input  logic                    s03_axis_tvalid,
    input  logic                    s03_axis_tlast,
    output logic                    s03_axis_tready,
    output logic [ACC_WIDTH-1:0]    m03_axis_tdata,
    output logic [ACC_WIDTH/8-1:0]  m03_axis_tstrb,
    output logic                    m03_axis_tvalid,
    output logic                    m03_axis_tlast,
    input  logic                    m03_axis_tready,
    output logic [CNT_WIDTH-1:0]    beat_count,
    output logic                    pkt_err
);

    localparam int                   IN_BYTES = DATA_WIDTH / 8;
    localparam logic [CNT_WIDTH-1:0] MAX_CNT  = CNT_WIDTH'(MAX_BEATS);

    typedef enum logic {
        S_ACC = 1'b0,
        S_OUT = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [ACC_WIDTH-1:0]  acc_q, acc_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [ACC_WIDTH-1:0]  res_data_q, res_data_d;
    logic [CNT_WIDTH-1:0]  res_cnt_q, res_cnt_d;
    logic                  res_err_q, res_err_d;

    logic [DATA_WIDTH-1:0] masked_word;
    logic [ACC_WIDTH-1:0]  acc_sum;
    logic [CNT_WIDTH-1:0]  cnt_inc;
    logic                  beat_acc;
    logic                  pkt_end;

    // Bytes with a cleared strobe contribute zero.
    always_comb begin
        masked_word = '0;
        for (int i = 0; i < IN_BYTES; i++) begin
            if (s03_axis_tstrb[i]) begin
                masked_word[i*8 +: 8] = s03_axis_tdata[i*8 +: 8];
            end
        end
    end

`ifdef ACC_SATURATE_EN
    // One extra carry bit detects overflow; once at all-ones any further
    // non-negative addend carries out again, so the sum stays pinned.
    logic [ACC_WIDTH:0] sum_ext;
    always_comb begin
        sum_ext = {1'b0, acc_q} + (ACC_WIDTH+1)'(masked_word);
        acc_sum = sum_ext[ACC_WIDTH] ? '1 : sum_ext[ACC_WIDTH-1:0];
    end
`else
    always_comb begin
        acc_sum = acc_q + ACC_WIDTH'(masked_word);
    end
`endif

    assign cnt_inc = cnt_q + CNT_WIDTH'(1'b1);

    // Gated by reset so the upstream never sees ready while we are held in reset.
    assign s03_axis_tready = s03_axis_aresetn && (state_q == S_ACC);
    assign beat_acc        = s03_axis_tvalid && s03_axis_tready;
    // Overlong packets are cut here; their remaining beats start a fresh packet.
    assign pkt_end         = s03_axis_tlast || (cnt_inc == MAX_CNT);

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        res_data_d = res_data_q;
        res_cnt_d  = res_cnt_q;
        res_err_d  = res_err_q;

        case (state_q)
            S_ACC: begin
                if (beat_acc) begin
                    if (pkt_end) begin
                        res_data_d = acc_sum;
                        res_cnt_d  = cnt_inc;
                        res_err_d  = !s03_axis_tlast;
                        acc_d      = '0;
                        cnt_d      = '0;
                        state_d    = S_OUT;
                    end else begin
                        acc_d = acc_sum;
                        cnt_d = cnt_inc;
                    end
                end
            end
            S_OUT: begin
                // Result registers are left untouched so they stay stable
                // for the whole stall; only the valid (state) drops.
                if (m03_axis_tready) begin
                    state_d = S_ACC;
                end
            end
            default: begin
                state_d = S_ACC;
            end
        endcase
    end

    always_ff @(posedge s03_axis_aclk or negedge s03_axis_aresetn) begin
        if (!s03_axis_aresetn) begin
            state_q    <= S_ACC;
            acc_q      <= '0;
            cnt_q      <= '0;
            res_data_q <= '0;
            res_cnt_q  <= '0;
            res_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            res_data_q <= res_data_d;
            res_cnt_q  <= res_cnt_d;
            res_err_q  <= res_err_d;
        end
    end

    assign m03_axis_tvalid = (state_q == S_OUT);
    assign m03_axis_tlast  = (state_q == S_OUT);
    assign m03_axis_tstrb  = (state_q == S_OUT) ? '1 : '0;
    assign m03_axis_tdata  = res_data_q;
    assign beat_count      = res_cnt_q;
    assign pkt_err         = res_err_q;

endmodule
